// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// the FSM state encoding and the default frame and baud parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned NDataDefault = 8;
  localparam int unsigned MStopDefault = 1;
  localparam int unsigned NTickDefault = 16;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N_DATA data bits LSB first, optional parity bit, M_STOP stop bits.
// Define UART_TX_PARITY_EN to build in the parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned N_DATA          = NDataDefault,
  parameter int unsigned M_STOP          = MStopDefault,
  parameter int unsigned EVEN_ODD_PARITY = 1,
  parameter int unsigned N_TICK          = NTickDefault
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_tx_start,
  input  logic [N_DATA-1:0] i_data,
  output logic              o_tx,
  output logic              o_tx_busy,
  output logic              o_tx_done
);

  localparam int unsigned TickW = (N_TICK > 1) ? $clog2(N_TICK) : 1;
  localparam int unsigned BitW  = $clog2(N_DATA + 1);

  if (M_STOP < 1 || M_STOP > 2 || EVEN_ODD_PARITY > 1) begin : g_bad_cfg
    $error("uart_tx: M_STOP must be 1 or 2 and EVEN_ODD_PARITY 0 or 1");
  end

  uart_state_e       state_q;
  logic [TickW-1:0]  tick_q;
  logic [BitW-1:0]   bit_q;
  logic [N_DATA-1:0] shreg_q;
  logic [N_DATA-1:0] shreg_nxt;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  assign bit_end   = i_tick && (tick_q == TickW'(N_TICK - 1));
  assign shreg_nxt = shreg_q >> 1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && i_tick) begin
        tick_q <= bit_end ? '0 : tick_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          // The done cycle still counts as part of the old frame, so starts are refused there.
          if (i_tx_start && !done_q) begin
            state_q <= StStart;
            shreg_q <= i_data;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^i_data) ^ (EVEN_ODD_PARITY != 0);
`endif
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            tx_q    <= shreg_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == BitW'(N_DATA - 1)) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= par_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shreg_nxt;
              tx_q    <= shreg_nxt[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_end) begin
            if (bit_q == BitW'(M_STOP - 1)) begin
              state_q <= StIdle;
              bit_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

endmodule
